periph_timer: RTL and testbench

Memory-mapped timer/LED/switch peripheral on the single-cycle CPU's data bus, decoded alongside data memory. Presents the CPU's load/store address, read strobe and write strobe. Its reload timer raises the `irq` line feeding the CPU controller's interrupt input. It also holds the board LED register and a synchronised switch input.

---
 rtl/periph_pkg.sv | 48 ++++
 rtl/periph_timer_sync_2ff.sv | 27 ++
 rtl/periph_timer.sv | 135 +++++++++++++
 tb/tb_periph_timer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_pkg.sv
// Shared constants and address decode for the timer/LED/switch peripheral.
// PERIPH_SYSTICK_EN (see periph_timer) maps the free-running counter at 0x14.
package periph_pkg;

    localparam logic [31:0] DEFAULT_BASE = 32'h4000_0000;
    localparam logic [31:0] TL_MAX       = 32'hFFFF_FFFF;

    localparam logic [4:0] OFF_TH      = 5'h00;
    localparam logic [4:0] OFF_TL      = 5'h04;
    localparam logic [4:0] OFF_TCON    = 5'h08;
    localparam logic [4:0] OFF_LED     = 5'h0C;
    localparam logic [4:0] OFF_SW      = 5'h10;
    localparam logic [4:0] OFF_SYSTICK = 5'h14;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_TH,
        SEL_TL,
        SEL_TCON,
        SEL_LED,
        SEL_SW,
        SEL_SYSTICK
    } sel_e;

    // Only exact word offsets hit; anything else inside the window is dead space.
    function automatic sel_e decode(input logic [31:0] addr,
                                    input logic [31:0] base);
        sel_e s;
        s = SEL_NONE;
        if (addr[31:5] == base[31:5]) begin
            case (addr[4:0])
                OFF_TH:      s = SEL_TH;
                OFF_TL:      s = SEL_TL;
                OFF_TCON:    s = SEL_TCON;
                OFF_LED:     s = SEL_LED;
                OFF_SW:      s = SEL_SW;
                OFF_SYSTICK: s = SEL_SYSTICK;
                default:     s = SEL_NONE;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/periph_timer_sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs.
// Parameterised width, asynchronous active-low reset.
module sync_2ff #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/periph_timer.sv
// Memory-mapped reload timer, LED register and synchronised switch input.
// Define PERIPH_SYSTICK_EN to add the free-running SYSTICK counter at 0x14.
module periph_timer
    import periph_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic [7:0]  led,
    input  logic [7:0]  switch
);

    sel_e sel;
    assign sel = decode(addr, BASE_ADDR);

    logic wr_th;
    logic wr_tl;
    logic wr_tcon;
    logic wr_led;
    assign wr_th   = wr && (sel == SEL_TH);
    assign wr_tl   = wr && (sel == SEL_TL);
    assign wr_tcon = wr && (sel == SEL_TCON);
    assign wr_led  = wr && (sel == SEL_LED);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic        en_q, en_d;
    logic        ie_q, ie_d;
    logic        is_q, is_d;
    logic [7:0]  led_q, led_d;
    logic [7:0]  sw;

    logic ovf;
    logic ovf_irq;
    assign ovf     = en_q && (tl_q == TL_MAX);
    assign ovf_irq = ovf && ie_q;

    always_comb begin
        th_d  = th_q;
        tl_d  = tl_q;
        en_d  = en_q;
        ie_d  = ie_q;
        is_d  = is_q | ovf_irq;
        led_d = led_q;
        if (ovf) begin
            tl_d = th_q;
        end else if (en_q) begin
            tl_d = tl_q + 32'd1;
        end
        if (wr_tl) begin
            tl_d = wdata;
        end
        if (wr_th) begin
            th_d = wdata;
        end
        // An overflow landing on an acknowledge must still leave IS set.
        if (wr_tcon) begin
            en_d = wdata[TCON_EN];
            ie_d = wdata[TCON_IE];
            is_d = wdata[TCON_IS] | ovf_irq;
        end
        if (wr_led) begin
            led_d = wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q  <= '0;
            tl_q  <= '0;
            en_q  <= 1'b0;
            ie_q  <= 1'b0;
            is_q  <= 1'b0;
            led_q <= '0;
        end else begin
            th_q  <= th_d;
            tl_q  <= tl_d;
            en_q  <= en_d;
            ie_q  <= ie_d;
            is_q  <= is_d;
            led_q <= led_d;
        end
    end

    sync_2ff #(
        .W(8)
    ) u_sw_sync (
        .clk  (clk),
        .rst_n(reset),
        .d_i  (switch),
        .q_o  (sw)
    );

`ifdef PERIPH_SYSTICK_EN
    logic [31:0] systick_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            systick_q <= '0;
        end else begin
            systick_q <= systick_q + 32'd1;
        end
    end
`endif

    always_comb begin
        rdata = '0;
        if (rd) begin
            unique case (sel)
                SEL_TH:   rdata = th_q;
                SEL_TL:   rdata = tl_q;
                SEL_TCON: rdata = {29'd0, is_q, ie_q, en_q};
                SEL_LED:  rdata = {24'd0, led_q};
                SEL_SW:   rdata = {24'd0, sw};
`ifdef PERIPH_SYSTICK_EN
                SEL_SYSTICK: rdata = systick_q;
`else
                SEL_SYSTICK: rdata = '0;
`endif
                default:  rdata = '0;
            endcase
        end
    end

    assign irq = is_q & ie_q;
    assign led = led_q;

endmodule

// File: tb/tb_periph_timer.sv
// Scoreboard bench for periph_timer: driver pushes model expectations,
// a negedge monitor pops and compares rdata, irq and led.
module tb_periph_timer;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] MAXV = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;
    logic [7:0]  led;
    logic [7:0]  sw_in = '0;

    always #5 clk = ~clk;

    periph_timer #(
        .BASE_ADDR(BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rd    (rd),
        .wr    (wr),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq),
        .led   (led),
        .switch(sw_in)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] rdata;
        logic        irq;
        logic [7:0]  led;
    } exp_t;

    exp_t sbq[$];
    int vectors = 0;
    int miscompares = 0;

    // Reference model: register file as plain variables
    logic [31:0] m_th, m_tl, m_tick;
    bit          m_en, m_ie, m_is;
    logic [7:0]  m_led;
    logic [7:0]  m_swq[$];

    function automatic void model_clear();
        m_th = '0; m_tl = '0; m_tick = '0;
        m_en = 0; m_ie = 0; m_is = 0;
        m_led = '0;
        m_swq.delete();
    endfunction

    // Switch value seen two sampling edges ago.
    function automatic logic [7:0] model_sw();
        if (m_swq.size() >= 2) return m_swq[1];
        return 8'h00;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r;
        r = '0;
        if (a[31:5] == BASE[31:5]) begin
            case (a[4:0])
                5'h00: r = m_th;
                5'h04: r = m_tl;
                5'h08: r = {29'd0, m_is, m_ie, m_en};
                5'h0C: r = {24'd0, m_led};
                5'h10: r = {24'd0, model_sw()};
`ifdef PERIPH_SYSTICK_EN
                5'h14: r = m_tick;
`endif
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    function automatic void model_edge(input bit w, input logic [31:0] a,
                                       input logic [31:0] d, input logic [7:0] s);
        bit hit, wrap, set_is;
        logic [31:0] ntl;
        hit = (a[31:5] == BASE[31:5]);
        wrap = m_en && (m_tl == MAXV);
        set_is = wrap && m_ie;
        if (w && hit && a[4:0] == 5'h04) ntl = d;
        else if (!m_en) ntl = m_tl;
        else if (wrap) ntl = m_th;
        else ntl = m_tl + 32'd1;
        if (w && hit && a[4:0] == 5'h08) begin
            m_is = d[2] | set_is;
            m_en = d[0];
            m_ie = d[1];
        end else begin
            m_is = m_is | set_is;
        end
        m_tl = ntl;
        if (w && hit && a[4:0] == 5'h00) m_th = d;
        if (w && hit && a[4:0] == 5'h0C) m_led = d[7:0];
        m_tick = m_tick + 32'd1;
        m_swq.push_front(s);
        if (m_swq.size() > 2) void'(m_swq.pop_back());
    endfunction

    task automatic bus(input bit rst_n, input bit r, input bit w,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [7:0] s);
        exp_t e;
        @(posedge clk);
        #2;
        reset = rst_n; rd = r; wr = w; addr = a; wdata = d; sw_in = s;
        if (!rst_n) model_clear();
        e.a = a;
        e.rdata = r ? model_read(a) : 32'h0;
        e.irq = m_is & m_ie;
        e.led = m_led;
        sbq.push_back(e);
        if (rst_n) model_edge(w, a, d, s);
    endtask

    task automatic rdreg(input logic [31:0] a);
        bus(1, 1, 0, a, 32'h0, sw_in);
    endtask

    task automatic wrreg(input logic [31:0] a, input logic [31:0] d);
        bus(1, 0, 1, a, d, sw_in);
    endtask

    // Step until the next cycle is an overflow cycle, bounded.
    task automatic wait_ovf(input string tag);
        int n;
        n = 0;
        while (!(m_en && m_tl == MAXV) && n < 200) begin
            rdreg(BASE + 32'h08);
            n++;
        end
        vectors++;
        if (n >= 200) begin
            miscompares++;
            $display("FAIL %s overflow_wait got=timeout exp=overflow", tag);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            vectors++;
            if (rdata !== e.rdata) begin
                miscompares++;
                $display("FAIL rdata addr=%h got=%h exp=%h", e.a, rdata, e.rdata);
            end
            vectors++;
            if (irq !== e.irq) begin
                miscompares++;
                $display("FAIL irq addr=%h got=%b exp=%b", e.a, irq, e.irq);
            end
            vectors++;
            if (led !== e.led) begin
                miscompares++;
                $display("FAIL led addr=%h got=%h exp=%h", e.a, led, e.led);
            end
        end
    end

    logic [31:0] alist [10];

    initial begin
        model_clear();
        alist[0] = BASE + 32'h00; alist[1] = BASE + 32'h04;
        alist[2] = BASE + 32'h08; alist[3] = BASE + 32'h0C;
        alist[4] = BASE + 32'h10; alist[5] = BASE + 32'h14;
        alist[6] = BASE + 32'h0D; alist[7] = BASE + 32'h18;
        alist[8] = 32'h0000_000C; alist[9] = BASE + 32'h02;

        // Reset held with switches at A5: everything reads zero
        for (int i = 0; i < 6; i++)
            bus(0, 1, 0, BASE + 32'(i * 4), 32'h0, 8'hA5);
        for (int i = 0; i < 4; i++)
            bus(1, 1, 0, BASE + 32'h10, 32'h0, 8'hA5);

        // Reload
        wrreg(BASE + 32'h00, 32'hFFFF_FFFC);
        wrreg(BASE + 32'h04, 32'hFFFF_FFFE);
        wrreg(BASE + 32'h08, 32'h3);
        rdreg(BASE + 32'h04);
        rdreg(BASE + 32'h04);
        rdreg(BASE + 32'h04);
        wrreg(BASE + 32'h08, 32'h3);
        for (int i = 0; i < 6; i++) rdreg(BASE + 32'h08);

        // Acknowledge race
        wrreg(BASE + 32'h08, 32'h3);
        wait_ovf("ack");
        wrreg(BASE + 32'h08, 32'h3);
        rdreg(BASE + 32'h08);
        rdreg(BASE + 32'h08);

        // Priority: TL write and TH write on overflow cycles
        wait_ovf("tl_prio");
        wrreg(BASE + 32'h04, 32'h5);
        rdreg(BASE + 32'h04);
        wrreg(BASE + 32'h04, 32'hFFFF_FFFD);
        wait_ovf("th_prio");
        wrreg(BASE + 32'h00, 32'h9);
        rdreg(BASE + 32'h04);
        rdreg(BASE + 32'h00);
        wrreg(BASE + 32'h08, 32'h0);

        // Decode holes and LED width
        wrreg(BASE + 32'h0D, 32'hDEAD_BEEF);
        wrreg(BASE + 32'h18, 32'h1234_5678);
        wrreg(32'h0000_000C, 32'h0000_00FF);
        for (int i = 0; i < 10; i++) rdreg(alist[i]);
        wrreg(BASE + 32'h0C, 32'h0000_01FF);
        rdreg(BASE + 32'h0C);

        // SYSTICK with EN=0
        rdreg(BASE + 32'h14);
        for (int i = 0; i < 9; i++) rdreg(BASE + 32'h04);
        rdreg(BASE + 32'h14);

        // Randomised traffic with occasional mid-run reset
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a, d;
            bit r, w, rn;
            a = alist[$urandom_range(9)];
            r = 1'($urandom_range(1));
            w = ($urandom_range(2) != 0);
            d = $urandom;
            if (a == BASE + 32'h04 || a == BASE + 32'h00)
                if ($urandom_range(3) != 0) d = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            rn = ($urandom_range(199) != 0);
            bus(rn, r, w, a, d, 8'($urandom));
        end

        bus(1, 0, 0, 32'h0, 32'h0, sw_in);
        repeat (2) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
